// File: rtl/dmem_arbiter.sv
// Shares a single-port, synchronous-read data memory between the MEM-stage core
// port and an external loader/debug port. Core has priority, bounded by a starvation counter.
module dmem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 9,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic       rsp_core;
    logic       rsp_ext;
    logic       core_req;
    logic       core_read;
    logic       ext_force;
    logic       gnt_ext;
    logic       gnt_core;

    // A store that also asserts core_rd is treated purely as a store.
    assign core_req  = core_rd | core_wr;
    assign core_read = core_rd & ~core_wr;
    assign ext_force = (wait_cnt == LIMIT);

    assign gnt_ext  = ~reset & ext_valid & (~core_req | ext_force);
    assign gnt_core = ~reset & core_req & ~gnt_ext;

    // Handshakes: an ext transfer happens on a cycle with ext_valid & ext_ready, and the
    // requester holds its fields stable while ext_valid & ~ext_ready. The core has no
    // ready; it holds its MEM stage for every cycle core_stall is high.
    assign ext_ready  = gnt_ext;
    assign core_stall = ~reset & core_req & ~gnt_core;

    always_comb begin
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_ext) begin
            mem_wr    = ext_we;
            mem_rd    = ~ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (gnt_core) begin
            mem_wr    = core_wr;
            mem_rd    = core_read;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // Counts consecutive denied ext cycles; saturation is defensive since ext_force grants first.
    always_comb begin
        wait_cnt_nxt = 4'd0;
        if (ext_valid && !gnt_ext) begin
            wait_cnt_nxt = ext_force ? LIMIT : wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            rsp_core <= 1'b0;
            rsp_ext  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            rsp_core <= gnt_core & core_read;
            rsp_ext  <= gnt_ext & ~ext_we;
        end
    end

    // Reset in the response cycle drops the in-flight read data.
    assign core_rvalid = rsp_core & ~reset;
    assign ext_rvalid  = rsp_ext & ~reset;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign ext_rdata   = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read memory attached.
module tb_dmem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic              core_rd;
    logic              core_wr;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              ext_valid;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ready;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, write lands on the edge
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] = mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
        ext_valid = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic test_reset();
        core_rd = 1'b1; core_addr = 9'h010;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h008;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset.mem_rd got %0h exp 0", mem_rd); end
        n_tests++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset.mem_wr got %0h exp 0", mem_wr); end
        n_tests++; if (mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset.mem_addr got %0h exp 0", mem_addr); end
        n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset.core_stall got %0h exp 0", core_stall); end
        n_tests++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL reset.ext_ready got %0h exp 0", ext_ready); end
        n_tests++; if ({core_rvalid, ext_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset.rvalid got %b exp 00", {core_rvalid, ext_rvalid}); end
        n_tests++; if (core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin n_fail++; $display("FAIL reset.rdata got %h/%h exp 0/0", core_rdata, ext_rdata); end
        tick();
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_core_read();
        core_rd = 1'b1; core_addr = 9'h010;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL core_read.mem_rd got %0h exp 1", mem_rd); end
        n_tests++; if (mem_addr !== 9'h010) begin n_fail++; $display("FAIL core_read.mem_addr got %h exp 010", mem_addr); end
        n_tests++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL core_read.core_stall got %0h exp 0", core_stall); end
        tick();
        idle();
        @(negedge clk);
        n_tests++; if (core_rvalid !== 1'b1) begin n_fail++; $display("FAIL core_read.core_rvalid got %0h exp 1", core_rvalid); end
        n_tests++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_read.core_rdata got %h exp deadbeef", core_rdata); end
        n_tests++; if (ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL core_read.ext_rvalid got %0h exp 0", ext_rvalid); end
        n_tests++; if (mem_addr !== 9'h000 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL idle.mem_fields got %h/%h exp 0/0", mem_addr, mem_wdata); end
        tick();
        @(negedge clk);
        n_tests++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin n_fail++; $display("FAIL core_read.after got %0h/%h exp 0/0", core_rvalid, core_rdata); end
        tick();
    endtask

    task automatic test_ext_write_read();
        ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 9'h1FF; ext_wdata = 32'h12345678;
        @(negedge clk);
        n_tests++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL ext_wr.ext_ready got %0h exp 1", ext_ready); end
        n_tests++; if ({mem_wr, mem_rd} !== 2'b10) begin n_fail++; $display("FAIL ext_wr.strobes got %b exp 10", {mem_wr, mem_rd}); end
        n_tests++; if (mem_addr !== 9'h1FF || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL ext_wr.fields got %h/%h exp 1ff/12345678", mem_addr, mem_wdata); end
        tick();
        ext_we = 1'b0; ext_wdata = '0;
        @(negedge clk);
        n_tests++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL ext_rd.ext_ready got %0h exp 1", ext_ready); end
        n_tests++; if ({mem_wr, mem_rd} !== 2'b01) begin n_fail++; $display("FAIL ext_rd.strobes got %b exp 01", {mem_wr, mem_rd}); end
        n_tests++; if (ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL ext_wr.no_rvalid got %0h exp 0", ext_rvalid); end
        tick();
        idle();
        @(negedge clk);
        n_tests++; if (ext_rvalid !== 1'b1) begin n_fail++; $display("FAIL ext_rd.ext_rvalid got %0h exp 1", ext_rvalid); end
        n_tests++; if (ext_rdata !== 32'h12345678) begin n_fail++; $display("FAIL ext_rd.ext_rdata got %h exp 12345678", ext_rdata); end
        n_tests++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL ext_rd.core_rvalid got %0h exp 0", core_rvalid); end
        tick();
    endtask

    task automatic test_interleaved();
        core_rd = 1'b1; core_addr = 9'h004;
        @(negedge clk);
        n_tests++; if (mem_addr !== 9'h004) begin n_fail++; $display("FAIL inter.core_addr got %h exp 004", mem_addr); end
        tick();
        core_rd = 1'b0; core_addr = '0;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h008;
        @(negedge clk);
        n_tests++; if (ext_ready !== 1'b1 || mem_addr !== 9'h008) begin n_fail++; $display("FAIL inter.ext_grant got %0h/%h exp 1/008", ext_ready, mem_addr); end
        n_tests++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hA) begin n_fail++; $display("FAIL inter.core_rsp got %0h/%h exp 1/0000000a", core_rvalid, core_rdata); end
        n_tests++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin n_fail++; $display("FAIL inter.ext_early got %0h/%h exp 0/0", ext_rvalid, ext_rdata); end
        tick();
        idle();
        @(negedge clk);
        n_tests++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hB) begin n_fail++; $display("FAIL inter.ext_rsp got %0h/%h exp 1/0000000b", ext_rvalid, ext_rdata); end
        n_tests++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin n_fail++; $display("FAIL inter.core_cross got %0h/%h exp 0/0", core_rvalid, core_rdata); end
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] exp_wait [0:7];
        logic       prev_core;
        logic       prev_ext;
        logic       exp_ext;
        exp_wait = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        prev_core = 1'b0;
        prev_ext  = 1'b0;
        core_rd = 1'b1; core_addr = 9'h004;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h008;
        for (int i = 0; i < 8; i++) begin
            exp_ext = ((i % 4) == 3);
            @(negedge clk);
            n_tests++; if (ext_ready !== exp_ext) begin n_fail++; $display("FAIL contend[%0d].ext_ready got %0h exp %0h", i, ext_ready, exp_ext); end
            n_tests++; if (core_stall !== exp_ext) begin n_fail++; $display("FAIL contend[%0d].core_stall got %0h exp %0h", i, core_stall, exp_ext); end
            n_tests++; if (mem_addr !== (exp_ext ? 9'h008 : 9'h004)) begin n_fail++; $display("FAIL contend[%0d].mem_addr got %h exp %h", i, mem_addr, exp_ext ? 9'h008 : 9'h004); end
            n_tests++; if ({core_rvalid, ext_rvalid} !== {prev_core, prev_ext}) begin n_fail++; $display("FAIL contend[%0d].rvalid got %b exp %b", i, {core_rvalid, ext_rvalid}, {prev_core, prev_ext}); end
            if (prev_core) begin
                n_tests++; if (core_rdata !== 32'hA) begin n_fail++; $display("FAIL contend[%0d].core_rdata got %h exp 0000000a", i, core_rdata); end
            end
            if (prev_ext) begin
                n_tests++; if (ext_rdata !== 32'hB) begin n_fail++; $display("FAIL contend[%0d].ext_rdata got %h exp 0000000b", i, ext_rdata); end
            end
            tick();
            n_tests++; if (dut.wait_cnt !== exp_wait[i]) begin n_fail++; $display("FAIL contend[%0d].wait_cnt got %0d exp %0d", i, dut.wait_cnt, exp_wait[i]); end
            prev_core = ~exp_ext;
            prev_ext  = exp_ext;
        end
        idle();
        @(negedge clk);
        n_tests++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hB) begin n_fail++; $display("FAIL contend.last_rsp got %0h/%h exp 1/0000000b", ext_rvalid, ext_rdata); end
        tick();
    endtask

    task automatic test_withdrawal();
        core_rd = 1'b1; core_addr = 9'h004;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h008;
        tick();
        tick();
        n_tests++; if (dut.wait_cnt !== 4'd2) begin n_fail++; $display("FAIL withdraw.pre got %0d exp 2", dut.wait_cnt); end
        ext_valid = 1'b0;
        tick();
        n_tests++; if (dut.wait_cnt !== 4'd0) begin n_fail++; $display("FAIL withdraw.clear got %0d exp 0", dut.wait_cnt); end
        ext_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (ext_ready !== (i == 3)) begin n_fail++; $display("FAIL withdraw[%0d].ext_ready got %0h exp %0h", i, ext_ready, (i == 3)); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        core_rd = 1'b1; core_addr = 9'h010;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rst_mid.grant got %0h exp 1", mem_rd); end
        tick();
        reset = 1'b1;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 9'h008;
        @(negedge clk);
        n_tests++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid.core_rsp got %0h/%h exp 0/0", core_rvalid, core_rdata); end
        n_tests++; if ({mem_rd, mem_wr} !== 2'b00 || mem_addr !== 9'h000) begin n_fail++; $display("FAIL rst_mid.mem got %b/%h exp 00/000", {mem_rd, mem_wr}, mem_addr); end
        n_tests++; if (core_stall !== 1'b0 || ext_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid.hs got %0h/%0h exp 0/0", core_stall, ext_ready); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (ext_ready !== (i == 3)) begin n_fail++; $display("FAIL rst_mid[%0d].ext_ready got %0h exp %0h", i, ext_ready, (i == 3)); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_illegal();
        core_rd = 1'b1; core_wr = 1'b1; core_addr = 9'h020; core_wdata = 32'h55;
        @(negedge clk);
        n_tests++; if ({mem_wr, mem_rd} !== 2'b10) begin n_fail++; $display("FAIL illegal.strobes got %b exp 10", {mem_wr, mem_rd}); end
        n_tests++; if (mem_wdata !== 32'h55 || mem_addr !== 9'h020) begin n_fail++; $display("FAIL illegal.fields got %h/%h exp 020/00000055", mem_addr, mem_wdata); end
        tick();
        core_wr = 1'b0; core_wdata = '0;
        @(negedge clk);
        n_tests++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL illegal.no_rvalid got %0h exp 0", core_rvalid); end
        tick();
        idle();
        @(negedge clk);
        n_tests++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h55) begin n_fail++; $display("FAIL illegal.readback got %0h/%h exp 1/00000055", core_rvalid, core_rdata); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[9'h010] = 32'hDEADBEEF;
        mem[9'h004] = 32'h0000000A;
        mem[9'h008] = 32'h0000000B;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_core_read();
        test_ext_write_read();
        test_interleaved();
        test_contention();
        test_withdrawal();
        test_reset_mid_read();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
